// File: rtl/vend_pkg.sv
// Shared display definitions: seven-segment font, blank code, digit map, BCD width.
package vend_pkg;

   localparam int BCD_W = 12;

   // Segment codes {dp,g,f,e,d,c,b,a}, active-high
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Digit positions on the 8-digit display (7 = leftmost)
   localparam logic [2:0] DIG_NEED_H  = 3'd7;
   localparam logic [2:0] DIG_NEED_T  = 3'd6;
   localparam logic [2:0] DIG_NEED_U  = 3'd5;
   localparam logic [2:0] DIG_GAP_H   = 3'd4;
   localparam logic [2:0] DIG_GAP_L   = 3'd3;
   localparam logic [2:0] DIG_RIGHT_H = 3'd2;
   localparam logic [2:0] DIG_RIGHT_T = 3'd1;
   localparam logic [2:0] DIG_RIGHT_U = 3'd0;

   // Nibble used internally to force a blank digit
   localparam logic [3:0] NIB_BLANK = 4'hF;

   typedef enum logic [1:0] {CONV_IDLE, CONV_RUN, CONV_DONE} conv_state_t;

   // Any nibble outside 0..9 renders dark
   function automatic logic [7:0] seg_font(input logic [3:0] n);
      case (n)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Replace leading zeros (hundreds, then tens) with the blank nibble
   function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      if (b[11:8] == 4'd0) r[11:8] = NIB_BLANK;
      if (b[11:4] == 8'd0) r[7:4]  = NIB_BLANK;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// 8-bit sequential double-dabble: IDLE samples, 8 shift-add-3 steps, one DONE cycle.
module bin2bcd_seq
   import vend_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       bin,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   conv_state_t        state;
   logic [BCD_W+7:0]   sr;
   logic [BCD_W+7:0]   sr_adj;
   logic [2:0]         step;

   // Add 3 to every BCD nibble that is 5 or more before the next shift
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 3; i++) begin
         if (sr[8+4*i +: 4] >= 4'd5) sr_adj[8+4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
      end
   end

   // Converter FSM; done is high exactly during the DONE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CONV_IDLE;
         sr    <= '0;
         step  <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            CONV_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sr    <= {{BCD_W{1'b0}}, bin};
                  step  <= '0;
                  state <= CONV_RUN;
               end
            end
            CONV_RUN: begin
               sr   <= {sr_adj[BCD_W+6:0], 1'b0};
               step <= step + 3'd1;
               if (step == 3'd7) begin
                  state <= CONV_DONE;
                  done  <= 1'b1;
               end
            end
            CONV_DONE: begin
               done  <= 1'b0;
               state <= CONV_IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= CONV_IDLE;
            end
         endcase
      end
   end

   assign bcd = sr[BCD_W+7:8];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 8-digit seven-segment driver for need / input-or-change money.
// Optional macro SEG_LZB_EN: leading-zero blanking within each 3-digit group.
module seg_scan_display
   import vend_pkg::*;
#(
   parameter int CLK_DIV = 100000
)(
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       disp_en,
   input  logic [7:0] need_money,
   input  logic [7:0] input_money,
   input  logic [7:0] change_money,
   input  logic       show_change,
   output logic [7:0] Bit_select,
   output logic [7:0] Seg_select
);

   localparam int            PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

   // Group 1 = need (left), group 0 = right value
   logic [1:0][7:0]       grp_bin;
   logic [1:0]            grp_done;
   logic [1:0][BCD_W-1:0] grp_bcd;
   logic [1:0][BCD_W-1:0] grp_reg;
   logic [1:0][BCD_W-1:0] grp_show;

   logic [PW-1:0] pre;
   logic [2:0]    idx;
   logic [3:0]    nib;
   logic [7:0]    seg_next;

   assign grp_bin[1] = need_money;
   assign grp_bin[0] = show_change ? change_money : input_money;

   // Converters free-run in lock-step; both leave reset together with start tied high
   for (genvar g = 0; g < 2; g++) begin : g_conv
      bin2bcd_seq u_conv (
         .clk   (sys_clk),
         .rst_n (sys_rst_n),
         .start (1'b1),
         .bin   (grp_bin[g]),
         .done  (grp_done[g]),
         .bcd   (grp_bcd[g])
      );
   end

   // Display registers only take complete results, never partial shift state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) grp_reg <= '0;
      else begin
         for (int g = 0; g < 2; g++)
            if (grp_done[g]) grp_reg[g] <= grp_bcd[g];
      end
   end

   // Prescaler and digit index keep running regardless of disp_en
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_LAST) begin
         pre <= '0;
         idx <= idx + 3'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Pick the nibble for the current digit and map it through the font
   always_comb begin
`ifdef SEG_LZB_EN
      grp_show[1] = blank_lead(grp_reg[1]);
      grp_show[0] = blank_lead(grp_reg[0]);
`else
      grp_show    = grp_reg;
`endif
      nib = NIB_BLANK;
      case (idx)
         DIG_NEED_H:  nib = grp_show[1][11:8];
         DIG_NEED_T:  nib = grp_show[1][7:4];
         DIG_NEED_U:  nib = grp_show[1][3:0];
         DIG_GAP_H:   nib = NIB_BLANK;
         DIG_GAP_L:   nib = NIB_BLANK;
         DIG_RIGHT_H: nib = grp_show[0][11:8];
         DIG_RIGHT_T: nib = grp_show[0][7:4];
         DIG_RIGHT_U: nib = grp_show[0][3:0];
         default:     nib = NIB_BLANK;
      endcase
      seg_next = seg_font(nib);
   end

   // Registered outputs; disp_en only gates what reaches the pins
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         Bit_select <= 8'h00;
         Seg_select <= SEG_BLANK;
      end else if (disp_en) begin
         Bit_select <= 8'h01 << idx;
         Seg_select <= seg_next;
      end else begin
         Bit_select <= 8'h00;
         Seg_select <= SEG_BLANK;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with a small arithmetic display model.
module tb_seg_scan_display;

   localparam int CLK_DIV = 4;
   localparam logic [7:0] FONT [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       disp_en = 1'b0;
   logic [7:0] need_money = 8'd0;
   logic [7:0] input_money = 8'd0;
   logic [7:0] change_money = 8'd0;
   logic       show_change = 1'b0;
   logic [7:0] Bit_select;
   logic [7:0] Seg_select;

   int errors = 0;
   int checks = 0;
   int cyc;

   seg_scan_display #(.CLK_DIV(CLK_DIV)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .disp_en      (disp_en),
      .need_money   (need_money),
      .input_money  (input_money),
      .change_money (change_money),
      .show_change  (show_change),
      .Bit_select   (Bit_select),
      .Seg_select   (Seg_select)
   );

   always #5 sys_clk = ~sys_clk;

   // Clock edges since reset release: the scan position is a pure function of it
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cyc <= 0;
      else            cyc <= cyc + 1;
   end

   function automatic int exp_idx(input int c);
      return ((c - 1) / CLK_DIV) % 8;
   endfunction

   function automatic logic [7:0] exp_bit(input int c);
      logic [7:0] b;
      b = 8'h01 << exp_idx(c);
      return b;
   endfunction

   // Expected segments for digit d given the two displayed values
   function automatic logic [7:0] exp_seg(input int d, input int need_v, input int right_v);
      int v, pos, dig;
      if (d == 3 || d == 4) return 8'h00;
      v   = (d >= 5) ? need_v : right_v;
      pos = (d >= 5) ? d - 5 : d;
      dig = (pos == 2) ? v / 100 : (pos == 1) ? (v / 10) % 10 : v % 10;
`ifdef SEG_LZB_EN
      if (pos == 2 && v < 100) return 8'h00;
      if (pos == 1 && v < 10)  return 8'h00;
`endif
      return FONT[dig];
   endfunction

   task automatic test_reset();
      logic [7:0] eb, es;
      sys_rst_n = 1'b0;
      disp_en   = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++;
      if (Bit_select !== 8'h00) begin
         errors++; $display("FAIL reset_bit got=%h exp=00", Bit_select);
      end
      checks++;
      if (Seg_select !== 8'h00) begin
         errors++; $display("FAIL reset_seg got=%h exp=00", Seg_select);
      end
      sys_rst_n = 1'b1;
      for (int k = 0; k < 36; k++) begin
         @(negedge sys_clk);
         eb = exp_bit(cyc);
         es = exp_seg(exp_idx(cyc), 0, 0);
         checks++;
         if (Bit_select !== eb || Seg_select !== es) begin
            errors++;
            $display("FAIL scan_seq cyc=%0d got=%h/%h exp=%h/%h", cyc, Bit_select, Seg_select, eb, es);
         end
      end
   endtask

   task automatic test_values(input int nv, input int iv, input int cv, input bit sc);
      logic [7:0] eb, es;
      int rv;
      @(negedge sys_clk);
      need_money   = 8'(nv);
      input_money  = 8'(iv);
      change_money = 8'(cv);
      show_change  = sc;
      rv = sc ? cv : iv;
      repeat (24) @(negedge sys_clk);
      for (int k = 0; k < 8 * CLK_DIV; k++) begin
         @(negedge sys_clk);
         eb = exp_bit(cyc);
         es = exp_seg(exp_idx(cyc), nv, rv);
         checks++;
         if (Bit_select !== eb || Seg_select !== es) begin
            errors++;
            $display("FAIL values n=%0d r=%0d cyc=%0d got=%h/%h exp=%h/%h",
                     nv, rv, cyc, Bit_select, Seg_select, eb, es);
         end
      end
   endtask

   task automatic test_step();
      int steps [6] = '{0, 1, 6, 16, 36, 86};
      int allowed [$];
      int nv, d;
      bit ok;
      logic [7:0] eb, es;
      @(negedge sys_clk);
      nv = 53;
      need_money  = 8'(nv);
      show_change = 1'b0;
      allowed.push_back(int'(input_money));
      for (int s = 0; s < 6; s++) begin
         input_money = 8'(steps[s]);
         allowed.push_back(steps[s]);
         for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            d = exp_idx(cyc);
            if (d <= 2) begin
               ok = 1'b0;
               foreach (allowed[a]) if (Seg_select === exp_seg(d, nv, allowed[a])) ok = 1'b1;
               checks++;
               if (!ok) begin
                  errors++; $display("FAIL step_mixed cyc=%0d digit=%0d got=%h", cyc, d, Seg_select);
               end
            end
         end
      end
      repeat (20) @(negedge sys_clk);
      for (int k = 0; k < 8 * CLK_DIV; k++) begin
         @(negedge sys_clk);
         eb = exp_bit(cyc);
         es = exp_seg(exp_idx(cyc), nv, 86);
         checks++;
         if (Bit_select !== eb || Seg_select !== es) begin
            errors++;
            $display("FAIL step_final cyc=%0d got=%h/%h exp=%h/%h", cyc, Bit_select, Seg_select, eb, es);
         end
      end
   endtask

   task automatic test_disable();
      logic [7:0] eb, es;
      @(negedge sys_clk);
      disp_en = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge sys_clk);
         checks++;
         if (Bit_select !== 8'h00 || Seg_select !== 8'h00) begin
            errors++; $display("FAIL disable cyc=%0d got=%h/%h exp=00/00", cyc, Bit_select, Seg_select);
         end
      end
      disp_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge sys_clk);
         eb = exp_bit(cyc);
         es = exp_seg(exp_idx(cyc), int'(need_money), int'(input_money));
         checks++;
         if (Bit_select !== eb || Seg_select !== es) begin
            errors++;
            $display("FAIL reenable cyc=%0d got=%h/%h exp=%h/%h", cyc, Bit_select, Seg_select, eb, es);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] eb, es;
      @(negedge sys_clk);
      disp_en     = 1'b1;
      show_change = 1'b0;
      need_money  = 8'd99;
      input_money = 8'd200;
      repeat (4) @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      checks++;
      if (Bit_select !== 8'h00 || Seg_select !== 8'h00) begin
         errors++; $display("FAIL reset_mid got=%h/%h exp=00/00", Bit_select, Seg_select);
      end
      need_money  = 8'd42;
      input_money = 8'd250;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (Bit_select !== 8'h01 || Seg_select !== exp_seg(0, 0, 0)) begin
         errors++;
         $display("FAIL reset_mid_clear got=%h/%h exp=01/%h", Bit_select, Seg_select, exp_seg(0, 0, 0));
      end
      repeat (22) @(negedge sys_clk);
      for (int k = 0; k < 8 * CLK_DIV; k++) begin
         @(negedge sys_clk);
         eb = exp_bit(cyc);
         es = exp_seg(exp_idx(cyc), 42, 250);
         checks++;
         if (Bit_select !== eb || Seg_select !== es) begin
            errors++;
            $display("FAIL reset_mid_fresh cyc=%0d got=%h/%h exp=%h/%h", cyc, Bit_select, Seg_select, eb, es);
         end
      end
   endtask

   initial begin
      test_reset();
      test_values(125, 37, 0, 1'b0);
      test_values(255, 0, 0, 1'b1);
      test_values(7, 7, 200, 1'b0);
      test_values(90, 3, 100, 1'b1);
      for (int r = 0; r < 4; r++)
         test_values($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      test_step();
      test_disable();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
